// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the CPU MEM-stage data-memory interface. A load/store
// request is accepted in IDLE, held for LAT_CYCLES wait cycles, then serviced
// against an internal array of DEPTH 32-bit words. The response (load data or
// store completion, plus an error flag) is held until the CPU takes it.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (state is IDLE)
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I size/sign code (B/H/W/BU/HU)
//   req_addr    byte address; word index is req_addr[31:2]
//   req_wdata   right-aligned store data
//   rsp_valid   response present
//   rsp_ready   CPU takes the response
//   rsp_rdata   extended load data; 0 for stores and errors
//   rsp_err     illegal funct3, misaligned, or out-of-range request
//   busy        block is not IDLE (CPU stalls its pipeline on this)
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH      = 32,
   parameter int LAT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   localparam logic [3:0]  LAT_W   = 4'(LAT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH];

   logic          w_err;
   logic          w_commit;
   logic          w_service;
   logic [IW-1:0] w_idx;
   logic [31:0]   w_word;
   logic [31:0]   w_load;
   logic [3:0]    w_be;
   logic [31:0]   w_wd;

   // Error check: funct3 legality for the access type, alignment, range.
   function automatic logic f_illegal(input logic        we,
                                      input logic [2:0]  f3,
                                      input logic [31:0] addr);
      logic bad;
      bad = 1'b0;
      case (f3)
         3'b000:         bad = 1'b0;
         3'b001, 3'b101: bad = addr[0] | (we & f3[2]);   // HU is load-only
         3'b010:         bad = (addr[1:0] != 2'b00);
         3'b100:         bad = we;                       // BU is load-only
         default:        bad = 1'b1;
      endcase
      if ({2'b00, addr[31:2]} >= DEPTH_W) begin
         bad = 1'b1;
      end else begin
         bad = bad;
      end
      return bad;
   endfunction

   // Load extraction: shift the addressed byte/half down, then extend.
   function automatic logic [31:0] f_load(input logic [2:0]  f3,
                                          input logic [1:0]  off,
                                          input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  res = {{24{sh[7]}}, sh[7:0]};
         3'b001:  res = {{16{sh[15]}}, sh[15:0]};
         3'b010:  res = word;
         3'b100:  res = {24'h000000, sh[7:0]};
         3'b101:  res = {16'h0000, sh[15:0]};
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   // Store byte-lane enables for the addressed byte/half/word.
   function automatic logic [3:0] f_be(input logic [2:0] f3,
                                       input logic [1:0] off);
      logic [3:0] be;
      case (f3)
         3'b000:  be = 4'b0001 << off;
         3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data replicated across lanes so each enabled lane sees its bytes.
   function automatic logic [31:0] f_wd(input logic [2:0]  f3,
                                        input logic [31:0] wd);
      logic [31:0] res;
      case (f3)
         3'b000:  res = {4{wd[7:0]}};
         3'b001:  res = {2{wd[15:0]}};
         default: res = wd;
      endcase
      return res;
   endfunction

   // Handshake status and request decode from the latched request.
   always_comb begin
      req_ready = (r_state == ST_IDLE);
      busy      = (r_state != ST_IDLE);
      rsp_valid = r_rsp_valid;
      rsp_rdata = r_rsp_rdata;
      rsp_err   = r_rsp_err;
      w_err     = f_illegal(r_we, r_funct3, r_addr);
      w_idx     = r_addr[IW+1:2];
      w_word    = r_mem[w_idx];
      w_load    = f_load(r_funct3, r_addr[1:0], w_word);
      w_be      = f_be(r_funct3, r_addr[1:0]);
      w_wd      = f_wd(r_funct3, r_wdata);
      // The counter is loaded with LAT_CYCLES and the request is serviced on
      // the edge after it has reached zero, giving rsp_valid at accept+LAT+1.
      w_service = (r_state == ST_WAIT) && (r_cnt == 4'd0);
      w_commit  = w_service && r_we && !w_err;
   end

   // Request/response FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= 32'h0000_0000;
         r_wdata     <= 32'h0000_0000;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0000_0000;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_cnt    <= LAT_W;
                  r_state  <= ST_WAIT;
               end else begin
                  r_state  <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (w_service) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= (w_err || r_we) ? 32'h0000_0000 : w_load;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               // New requests are not looked at here; they wait for IDLE.
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
               end else begin
                  r_state     <= ST_RESP;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   // Word array write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_commit && w_be[i]) begin
            r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;
   logic        va, vb;
   logic        rdy_a, rdy_b, rv_a, rv_b, err_a, err_b, busy_a, busy_b;
   logic [31:0] rd_a, rd_b;
   logic        sel;
   logic        m_rdy, m_rv, m_err, m_busy;
   logic [31:0] m_rd;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(32), .LAT_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(va), .req_ready(rdy_a), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a),
      .rsp_err(err_a), .busy(busy_a)
   );

   dmem_responder #(.DEPTH(32), .LAT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(vb), .req_ready(rdy_b), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b),
      .rsp_err(err_b), .busy(busy_b)
   );

   assign m_rdy  = sel ? rdy_b  : rdy_a;
   assign m_rv   = sel ? rv_b   : rv_a;
   assign m_err  = sel ? err_b  : err_a;
   assign m_busy = sel ? busy_b : busy_a;
   assign m_rd   = sel ? rd_b   : rd_a;

   // Issue one request to the selected DUT, return response and accept-to-valid edges.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdata,
                         output logic err, output int lat);
      int k;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
      if (sel) vb = 1'b1; else va = 1'b1;
      k = 0;
      while (!m_rdy && k < 40) begin @(negedge clk); k++; end
      if (!m_rdy) begin
         total++; bad++;
         $display("FAIL accept_timeout addr=%h", addr);
      end
      @(posedge clk);
      @(negedge clk);
      va = 1'b0; vb = 1'b0;
      k = 0;
      while (!m_rv && k < 40) begin @(negedge clk); k++; end
      if (!m_rv) begin
         total++; bad++;
         $display("FAIL rsp_timeout addr=%h", addr);
      end
      lat = k; rdata = m_rd; err = m_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total += 5;
      if (rv_a !== 1'b0)          begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rv_a); end
      if (rd_a !== 32'h0)         begin bad++; $display("FAIL rst_rdata got=%h exp=0", rd_a); end
      if (err_a !== 1'b0)         begin bad++; $display("FAIL rst_err got=%b exp=0", err_a); end
      if (rdy_a !== 1'b1)         begin bad++; $display("FAIL rst_req_ready got=%b exp=1", rdy_a); end
      if (busy_a !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_store_load();
      logic [31:0] d; logic e; int l;
      do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, d, e, l);
      total += 4;
      if (l !== 3)                begin bad++; $display("FAIL sw_latency got=%0d exp=3", l); end
      if (e !== 1'b0)             begin bad++; $display("FAIL sw_err got=%b exp=0", e); end
      if (d !== 32'h0)            begin bad++; $display("FAIL sw_rdata got=%h exp=0", d); end
      do_req(1'b0, 3'b010, 32'h8, 32'h0, d, e, l);
      if (d !== 32'hDEADBEEF)     begin bad++; $display("FAIL lw8 got=%h exp=deadbeef", d); end
   endtask

   task automatic test_byte_half();
      logic [31:0] d; logic e; int l;
      do_req(1'b1, 3'b000, 32'h9, 32'h00000080, d, e, l);
      total += 8;
      do_req(1'b0, 3'b000, 32'h9, 32'h0, d, e, l);
      if (d !== 32'hFFFFFF80)     begin bad++; $display("FAIL lb9 got=%h exp=ffffff80", d); end
      do_req(1'b0, 3'b100, 32'h9, 32'h0, d, e, l);
      if (d !== 32'h00000080)     begin bad++; $display("FAIL lbu9 got=%h exp=00000080", d); end
      do_req(1'b0, 3'b010, 32'h8, 32'h0, d, e, l);
      if (d !== 32'hDEAD80EF)     begin bad++; $display("FAIL lw8_after_sb got=%h exp=dead80ef", d); end
      do_req(1'b0, 3'b001, 32'hA, 32'h0, d, e, l);
      if (d !== 32'hFFFFDEAD)     begin bad++; $display("FAIL lhA got=%h exp=ffffdead", d); end
      do_req(1'b0, 3'b101, 32'hA, 32'h0, d, e, l);
      if (d !== 32'h0000DEAD)     begin bad++; $display("FAIL lhuA got=%h exp=0000dead", d); end
      do_req(1'b0, 3'b001, 32'h9, 32'h0, d, e, l);
      if (e !== 1'b1)             begin bad++; $display("FAIL lh9_err got=%b exp=1", e); end
      if (d !== 32'h0)            begin bad++; $display("FAIL lh9_rdata got=%h exp=0", d); end
      if (l !== 3)                begin bad++; $display("FAIL err_latency got=%0d exp=3", l); end
   endtask

   task automatic test_misalign();
      logic [31:0] d; logic e; int l;
      total += 4;
      do_req(1'b1, 3'b010, 32'h4, 32'h11223344, d, e, l);
      if (e !== 1'b0)             begin bad++; $display("FAIL sw4_err got=%b exp=0", e); end
      do_req(1'b1, 3'b010, 32'h6, 32'hAAAAAAAA, d, e, l);
      if (e !== 1'b1)             begin bad++; $display("FAIL sw6_err got=%b exp=1", e); end
      do_req(1'b1, 3'b001, 32'h5, 32'h0000BBBB, d, e, l);
      if (e !== 1'b1)             begin bad++; $display("FAIL sh5_err got=%b exp=1", e); end
      do_req(1'b0, 3'b010, 32'h4, 32'h0, d, e, l);
      if (d !== 32'h11223344)     begin bad++; $display("FAIL lw4_unchanged got=%h exp=11223344", d); end
   endtask

   task automatic test_range_funct3();
      logic [31:0] d; logic e; int l;
      total += 7;
      do_req(1'b1, 3'b010, 32'h0, 32'h55667788, d, e, l);
      do_req(1'b1, 3'b010, 32'h80, 32'h99999999, d, e, l);
      if (e !== 1'b1)             begin bad++; $display("FAIL sw80_err got=%b exp=1", e); end
      do_req(1'b0, 3'b010, 32'h0, 32'h0, d, e, l);
      if (d !== 32'h55667788)     begin bad++; $display("FAIL lw0_no_alias got=%h exp=55667788", d); end
      do_req(1'b0, 3'b011, 32'h8, 32'h0, d, e, l);
      if (e !== 1'b1)             begin bad++; $display("FAIL ld_f3_011_err got=%b exp=1", e); end
      if (d !== 32'h0)            begin bad++; $display("FAIL ld_f3_011_rdata got=%h exp=0", d); end
      do_req(1'b1, 3'b100, 32'h8, 32'h000000FF, d, e, l);
      if (e !== 1'b1)             begin bad++; $display("FAIL sb_f3_100_err got=%b exp=1", e); end
      do_req(1'b1, 3'b101, 32'h8, 32'h0000FFFF, d, e, l);
      if (e !== 1'b1)             begin bad++; $display("FAIL sh_f3_101_err got=%b exp=1", e); end
      do_req(1'b0, 3'b010, 32'h8, 32'h0, d, e, l);
      if (d !== 32'hDEAD80EF)     begin bad++; $display("FAIL lw8_after_bad_stores got=%h exp=dead80ef", d); end
   endtask

   task automatic test_back_to_back();
      int k;
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0;
      rsp_ready = 1'b0; va = 1'b1;
      @(posedge clk);
      k = 0;
      @(negedge clk);
      while (!rv_a && k < 40) begin @(negedge clk); k++; end
      total++;
      if (!rv_a)                  begin bad++; $display("FAIL hold_rsp_timeout"); end
      for (int c = 0; c < 5; c++) begin
         total += 4;
         if (rv_a !== 1'b1)        begin bad++; $display("FAIL hold_rsp_valid c=%0d got=%b exp=1", c, rv_a); end
         if (rd_a !== 32'hDEAD80EF) begin bad++; $display("FAIL hold_rdata c=%0d got=%h exp=dead80ef", c, rd_a); end
         if (rdy_a !== 1'b0)       begin bad++; $display("FAIL hold_req_ready c=%0d got=%b exp=0", c, rdy_a); end
         if (busy_a !== 1'b1)      begin bad++; $display("FAIL hold_busy c=%0d got=%b exp=1", c, busy_a); end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total += 3;
      if (rv_a !== 1'b0)          begin bad++; $display("FAIL b2b_rsp_cleared got=%b exp=0", rv_a); end
      if (rdy_a !== 1'b1)         begin bad++; $display("FAIL b2b_idle_gap got=%b exp=1", rdy_a); end
      @(negedge clk);
      va = 1'b0;
      if (busy_a !== 1'b1)        begin bad++; $display("FAIL b2b_accept_next got=%b exp=1", busy_a); end
      k = 0;
      while (!rv_a && k < 40) begin @(negedge clk); k++; end
      total += 2;
      if (k !== 3)                begin bad++; $display("FAIL b2b_latency got=%0d exp=3", k); end
      if (rd_a !== 32'hDEAD80EF)  begin bad++; $display("FAIL b2b_rdata got=%h exp=dead80ef", rd_a); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic e; int l;
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h12345678;
      rsp_ready = 1'b0; va = 1'b1;
      @(posedge clk);
      @(negedge clk);
      va = 1'b0;
      total += 4;
      if (busy_a !== 1'b1)        begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy_a); end
      #2 rst = 1'b0;
      #1;
      if (rv_a !== 1'b0)          begin bad++; $display("FAIL mid_rsp_valid got=%b exp=0", rv_a); end
      if (busy_a !== 1'b0)        begin bad++; $display("FAIL mid_busy_async got=%b exp=0", busy_a); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      if (rdy_a !== 1'b1)         begin bad++; $display("FAIL mid_req_ready got=%b exp=1", rdy_a); end
      total += 2;
      do_req(1'b0, 3'b010, 32'h8, 32'h0, d, e, l);
      if (d !== 32'hDEAD80EF)     begin bad++; $display("FAIL mid_old_data got=%h exp=dead80ef", d); end
      if (e !== 1'b0)             begin bad++; $display("FAIL mid_lw_err got=%b exp=0", e); end
   endtask

   task automatic test_lat0();
      logic [31:0] d; logic e; int l;
      sel = 1'b1;
      total += 4;
      do_req(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, d, e, l);
      if (l !== 1)                begin bad++; $display("FAIL lat0_sw_latency got=%0d exp=1", l); end
      if (e !== 1'b0)             begin bad++; $display("FAIL lat0_sw_err got=%b exp=0", e); end
      do_req(1'b0, 3'b001, 32'h12, 32'h0, d, e, l);
      if (l !== 1)                begin bad++; $display("FAIL lat0_lh_latency got=%0d exp=1", l); end
      if (d !== 32'hFFFFCAFE)     begin bad++; $display("FAIL lat0_lh got=%h exp=ffffcafe", d); end
      sel = 1'b0;
   endtask

   initial begin
      rst = 1'b0; va = 1'b0; vb = 1'b0; sel = 1'b0; rsp_ready = 1'b0;
      req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      test_reset();
      test_store_load();
      test_byte_half();
      test_misalign();
      test_range_funct3();
      test_back_to_back();
      test_reset_mid();
      test_lat0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
